// File: rtl/control_scoreboard_pkg.sv
// Shared types and default sizes for the register-hazard scoreboard.
// The FSM state type is sb_state_t: RUN, DRAIN, HALTED.
package control_scoreboard_pkg;

  localparam int DEFAULT_NUM_SREGS = 32;
  localparam int DEFAULT_NUM_VREGS = 32;
  localparam int DEFAULT_CNT_W     = 2;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } sb_state_t;

endpackage : control_scoreboard_pkg

// File: rtl/control_scoreboard_if.sv
// Decoded issue bus, retire reports and status outputs of the scoreboard.
// The master modport drives instructions and retires; the slave modport is the scoreboard side.
interface control_scoreboard_if #(
  parameter int SW = 5,
  parameter int VW = 5
);

  logic          issue_valid;
  logic          r_read1;
  logic          r_read2;
  logic [SW-1:0] scalar_read_register1;
  logic [SW-1:0] scalar_read_register2;
  logic          v_read1;
  logic          v_read2;
  logic [VW-1:0] vector_read_register1;
  logic [VW-1:0] vector_read_register2;
  logic          register_wr_en;
  logic [SW-1:0] scalar_write_register;
  logic          vector_wr_en;
  logic [VW-1:0] vector_write_register;
  logic          halt;
  logic          s_retire_valid;
  logic [SW-1:0] s_retire_reg;
  logic          v_retire_valid;
  logic [VW-1:0] v_retire_reg;
  logic          issue_stall;
  logic          halted;
  logic          sb_empty;
  logic          sb_error;

  modport master (
    output issue_valid, r_read1, r_read2, scalar_read_register1, scalar_read_register2,
           v_read1, v_read2, vector_read_register1, vector_read_register2,
           register_wr_en, scalar_write_register, vector_wr_en, vector_write_register,
           halt, s_retire_valid, s_retire_reg, v_retire_valid, v_retire_reg,
    input  issue_stall, halted, sb_empty, sb_error
  );

  modport slave (
    input  issue_valid, r_read1, r_read2, scalar_read_register1, scalar_read_register2,
           v_read1, v_read2, vector_read_register1, vector_read_register2,
           register_wr_en, scalar_write_register, vector_wr_en, vector_write_register,
           halt, s_retire_valid, s_retire_reg, v_retire_valid, v_retire_reg,
    output issue_stall, halted, sb_empty, sb_error
  );

endinterface : control_scoreboard_if

// File: rtl/control_scoreboard_sb_counter_file.sv
// Array of pending-write counters, one per architectural register, with one
// increment and one decrement port per cycle and busy/full/empty/error flags.
module sb_counter_file #(
  parameter int NUM_REGS   = 32,
  parameter int CNT_W      = 2,
  parameter bit TRACK_ZERO = 1'b1,
  parameter int IW         = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                inc_en,
  input  logic [IW-1:0]       inc_idx,
  input  logic                dec_en,
  input  logic [IW-1:0]       dec_idx,
  output logic [NUM_REGS-1:0] busy,
  output logic [NUM_REGS-1:0] full,
  output logic                empty,
  output logic                err
);

  logic [NUM_REGS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_REGS-1:0]            inc_hit, dec_hit;

  // NOTE: every variable written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    inc_hit = '0;
    dec_hit = '0;
    if (inc_en && (TRACK_ZERO || inc_idx != '0)) inc_hit[inc_idx] = 1'b1;
    if (dec_en && (TRACK_ZERO || dec_idx != '0)) dec_hit[dec_idx] = 1'b1;
  end

  // A same-register increment and decrement cancel; a decrement of zero clamps and flags.
  always_comb begin
    cnt_d = cnt_q;
    err   = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (inc_hit[i] && !dec_hit[i]) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (dec_hit[i] && !inc_hit[i]) begin
        if (cnt_q[i] == '0) err = 1'b1;
        else                cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      busy[i] = (cnt_q[i] != '0);
      full[i] = &cnt_q[i];
    end
    empty = ~|busy;
  end

  // NOTE: the counter array is architectural state and must clear on reset, unlike a plain data RAM.
  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule : sb_counter_file

// File: rtl/control_scoreboard.sv
// Register-hazard scoreboard at decode/issue with halt sequencing (RUN -> DRAIN -> HALTED).
// Vector file tracking is built only when SCOREBOARD_VECTOR_EN is defined.
module control_scoreboard
  import control_scoreboard_pkg::*;
#(
  parameter int NUM_SREGS = DEFAULT_NUM_SREGS,
  parameter int NUM_VREGS = DEFAULT_NUM_VREGS,
  parameter int CNT_W     = DEFAULT_CNT_W,
  parameter int SW        = $clog2(NUM_SREGS),
  parameter int VW        = $clog2(NUM_VREGS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  control_scoreboard_if.slave  bus
);

  sb_state_t           state_q, state_d;
  logic                error_q, error_d;
  logic [NUM_SREGS-1:0] s_busy, s_full;
  logic                s_empty, s_err;
  logic                v_raw, v_sat, v_empty, v_err;
  logic                s_raw, s_sat, hazard, stall, accept;

  // Register 0 is untracked, so its busy/full bits are constant zero.
  sb_counter_file #(
    .NUM_REGS  (NUM_SREGS),
    .CNT_W     (CNT_W),
    .TRACK_ZERO(1'b0),
    .IW        (SW)
  ) u_scalar_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc_en (accept && bus.register_wr_en && !bus.halt),
    .inc_idx(bus.scalar_write_register),
    .dec_en (bus.s_retire_valid),
    .dec_idx(bus.s_retire_reg),
    .busy   (s_busy),
    .full   (s_full),
    .empty  (s_empty),
    .err    (s_err)
  );

  assign s_raw = (bus.r_read1 && s_busy[bus.scalar_read_register1])
              || (bus.r_read2 && s_busy[bus.scalar_read_register2]);
  assign s_sat = bus.register_wr_en && !bus.halt && s_full[bus.scalar_write_register];

`ifdef SCOREBOARD_VECTOR_EN
  logic [NUM_VREGS-1:0] v_busy, v_full;

  sb_counter_file #(
    .NUM_REGS  (NUM_VREGS),
    .CNT_W     (CNT_W),
    .TRACK_ZERO(1'b1),
    .IW        (VW)
  ) u_vector_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc_en (accept && bus.vector_wr_en),
    .inc_idx(bus.vector_write_register),
    .dec_en (bus.v_retire_valid),
    .dec_idx(bus.v_retire_reg),
    .busy   (v_busy),
    .full   (v_full),
    .empty  (v_empty),
    .err    (v_err)
  );

  assign v_raw = (bus.v_read1 && v_busy[bus.vector_read_register1])
              || (bus.v_read2 && v_busy[bus.vector_read_register2]);
  assign v_sat = bus.vector_wr_en && v_full[bus.vector_write_register];
`else
  assign v_raw   = 1'b0;
  assign v_sat   = 1'b0;
  assign v_empty = 1'b1;
  assign v_err   = 1'b0;
`endif

  assign hazard = bus.issue_valid && (s_raw || s_sat || v_raw || v_sat);
  assign stall  = (state_q != RUN) || hazard;
  assign accept = bus.issue_valid && !stall;

  // DRAIN waits on the registered counters, so an already-empty board drains in one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (accept && bus.halt)  state_d = DRAIN;
      DRAIN:   if (s_empty && v_empty)  state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  assign error_d = error_q || s_err || v_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      error_q <= error_d;
    end
  end

  assign bus.issue_stall = stall;
  assign bus.halted      = (state_q == HALTED);
  assign bus.sb_empty    = s_empty && v_empty;
  assign bus.sb_error    = error_q;

endmodule : control_scoreboard
